// File: rtl/trigger_capture_pkg.sv
// Shared definitions for the trigger/capture sequencer and the RAM/display address logic.
package trigger_capture_pkg;

  localparam int BUFFER_LEN_DEF = 512;
  localparam int ADDR_W_DEF     = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

  // Threshold helpers work in 9 bits so level +/- hyst clamps instead of wrapping.
  function automatic logic [7:0] level_lo(input logic [7:0] level, input logic [3:0] hyst);
    logic [8:0] diff;
    diff = {1'b0, level} - {5'd0, hyst};
    return diff[8] ? 8'd0 : diff[7:0];
  endfunction

  function automatic logic [7:0] level_hi(input logic [7:0] level, input logic [3:0] hyst);
    logic [8:0] sum;
    sum = {1'b0, level} + {5'd0, hyst};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/trigger_capture_detect.sv
// Hysteresis edge detector: arms a flag once the signal is clearly on the far side
// of the level, then flags the first qualified sample that crosses the level.
module trigger_detect
  import trigger_capture_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_clear,
  input  logic       i_slope,
  input  logic [7:0] i_sample,
  input  logic [7:0] i_level,
  input  logic [3:0] i_hyst,
  output logic       o_trig
);

  logic       flag_q, flag_d;
  logic [7:0] thr_lo, thr_hi;
  logic       arm_cond, hit;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    thr_lo   = level_lo(i_level, i_hyst);
    thr_hi   = level_hi(i_level, i_hyst);
    arm_cond = 1'b0;
    hit      = 1'b0;
    if (i_slope == SLOPE_FALL) begin
      arm_cond = i_sample > thr_hi;
      hit      = i_sample <= i_level;
    end else begin
      arm_cond = i_sample < thr_lo;
      hit      = i_sample >= i_level;
    end
    // Decision uses the flag as it stood before this sample.
    o_trig = i_en && flag_q && hit;
    flag_d = flag_q;
    if (i_clear) begin
      flag_d = 1'b0;
    end else if (i_en && arm_cond) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (i_rst) flag_q <= 1'b0;
    else       flag_q <= flag_d;
  end

endmodule

// File: rtl/trigger_capture.sv
// Arm/pre-fill/trigger/post-fill sequencer writing ADC samples into a circular
// capture buffer and reporting the start address of each completed window.
module trigger_capture
  import trigger_capture_pkg::*;
#(
  parameter int BUFFER_LEN   = BUFFER_LEN_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int PRE_LEN      = 256,
  parameter int AUTO_TIMEOUT = 1000000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_sample_en,
  input  logic [7:0]        i_adc_data,
  input  logic [7:0]        i_level,
  input  logic [3:0]        i_hyst,
  input  logic              i_slope,
  input  logic              i_auto,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic [ADDR_W-1:0] o_start_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_auto_trig
);

  localparam int POST_LEN = BUFFER_LEN - PRE_LEN - 1;
  localparam int TMO_W    = $clog2(AUTO_TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_LEN - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_LEN - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_LEN);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(AUTO_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  TMO_SAT   = TMO_W'(AUTO_TIMEOUT);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]  start_addr_q, start_addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               auto_trig_q, auto_trig_d;

  logic start_ok, det_en, det_trig, force_trig, writing;

  assign start_ok = (state_q == ST_IDLE) && i_start && !i_stop;
  assign det_en   = (state_q == ST_ARMED) && i_sample_en && !i_stop;

  trigger_detect u_detect (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (det_en),
    .i_clear  (start_ok),
    .i_slope  (i_slope),
    .i_sample (i_adc_data),
    .i_level  (i_level),
    .i_hyst   (i_hyst),
    .o_trig   (det_trig)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    start_addr_d = start_addr_q;
    done_d       = 1'b0;
    auto_trig_d  = auto_trig_q;
    writing      = 1'b0;
    force_trig   = det_en && i_auto && (tmo_q >= TMO_LAST);

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d     = ST_PRE;
          ptr_d       = '0;
          cnt_d       = '0;
          tmo_d       = '0;
          auto_trig_d = 1'b0;
        end
      end
      ST_PRE: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (i_sample_en) begin
          writing = 1'b1;
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            state_d = ST_ARMED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (i_sample_en) begin
          writing = 1'b1;
          if (tmo_q != TMO_SAT) tmo_d = tmo_q + 1'b1;
          if (det_trig || force_trig) begin
            state_d      = ST_POST;
            cnt_d        = '0;
            start_addr_d = ptr_q - PRE_OFS;
            auto_trig_d  = !det_trig;
          end
        end
      end
      ST_POST: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (i_sample_en) begin
          writing = 1'b1;
          if (cnt_q == POST_LAST) state_d = ST_DONE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = !i_stop;
      end
      default: state_d = ST_IDLE;
    endcase

    if (writing) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = i_adc_data;
      ptr_d     = ptr_q + 1'b1;
    end
    // Busy spans DONE too, so it drops on the same edge that raises o_done.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      start_addr_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      auto_trig_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      start_addr_q <= start_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      auto_trig_q  <= auto_trig_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_start_addr = start_addr_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_auto_trig  = auto_trig_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: a sample-count model checked every cycle,
// plus hand-computed expectations for each capture scenario.
module tb_trigger_capture;

  localparam int BL = 16;
  localparam int AW = 4;
  localparam int PL = 4;
  localparam int AT = 20;

  logic clk = 1'b0;
  logic rst;
  logic i_start, i_stop, i_sample_en, i_slope, i_auto;
  logic [7:0] i_adc_data, i_level;
  logic [3:0] i_hyst;
  logic o_wr_en, o_busy, o_done, o_auto_trig;
  logic [AW-1:0] o_wr_addr, o_start_addr;
  logic [7:0] o_wr_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  trigger_capture #(.BUFFER_LEN(BL), .ADDR_W(AW), .PRE_LEN(PL), .AUTO_TIMEOUT(AT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_sample_en  (i_sample_en),
    .i_adc_data   (i_adc_data),
    .i_level      (i_level),
    .i_hyst       (i_hyst),
    .i_slope      (i_slope),
    .i_auto       (i_auto),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_start_addr (o_start_addr),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_auto_trig  (o_auto_trig)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: tracks writes since arm and the write index of the trigger sample;
  // phase (pre / armed / post) follows from those counts.
  bit m_active, m_done_pend, m_flag;
  int m_nw, m_trig_at, m_tmo;
  logic e_wr_en = 0, e_busy = 0, e_done = 0, e_auto = 0;
  logic [AW-1:0] e_wr_addr = 0, e_start = 0;
  logic [7:0] e_wr_data = 0;

  always @(posedge clk or posedge rst) begin : model
    int s, lo, hi;
    bit hit;
    if (rst) begin
      m_active = 0; m_done_pend = 0; m_flag = 0;
      m_nw = 0; m_trig_at = -1; m_tmo = 0;
      e_wr_en = 0; e_busy = 0; e_done = 0; e_auto = 0;
      e_wr_addr = 0; e_start = 0; e_wr_data = 0;
    end else begin
      e_wr_en = 0;
      e_done  = 0;
      if (m_done_pend) begin
        m_done_pend = 0;
        e_busy = 0;
        e_done = !i_stop;
      end else if (!m_active) begin
        if (i_start && !i_stop) begin
          m_active = 1; m_nw = 0; m_trig_at = -1; m_flag = 0; m_tmo = 0;
          e_auto = 0; e_busy = 1;
        end
      end else if (i_stop) begin
        m_active = 0;
        e_busy = 0;
      end else if (i_sample_en) begin
        s = int'(i_adc_data);
        e_wr_en = 1;
        e_wr_addr = AW'(m_nw % BL);
        e_wr_data = i_adc_data;
        if (m_nw >= PL && m_trig_at < 0) begin
          m_tmo++;
          lo = int'(i_level) - int'(i_hyst);
          if (lo < 0) lo = 0;
          hi = int'(i_level) + int'(i_hyst);
          if (hi > 255) hi = 255;
          if (i_slope == 1'b0) begin
            hit = m_flag && (s >= int'(i_level));
            if (s < lo) m_flag = 1;
          end else begin
            hit = m_flag && (s <= int'(i_level));
            if (s > hi) m_flag = 1;
          end
          if (!hit && i_auto && m_tmo >= AT) begin
            hit = 1;
            e_auto = 1;
          end
          if (hit) begin
            m_trig_at = m_nw;
            e_start = AW'((m_nw - PL) % BL);
          end
        end
        m_nw++;
        if (m_trig_at >= 0 && (m_nw - m_trig_at) == BL - PL) begin
          m_active = 0;
          m_done_pend = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("wr_en", o_wr_en, e_wr_en);
    if (e_wr_en) begin
      check("wr_addr", o_wr_addr, e_wr_addr);
      check("wr_data", o_wr_data, e_wr_data);
    end
    check("busy", o_busy, e_busy);
    check("done", o_done, e_done);
    check("start_addr", o_start_addr, e_start);
    check("auto_trig", o_auto_trig, e_auto);
  end

  logic [AW-1:0] log_addr[$];
  logic [7:0]    log_data[$];
  always @(negedge clk) begin
    if (o_wr_en === 1'b1) begin
      log_addr.push_back(o_wr_addr);
      log_data.push_back(o_wr_data);
    end
  end

  function automatic logic [7:0] pat(input int pid, input int k);
    case (pid)
      1:       return (k * 10 > 250) ? 8'd250 : 8'(k * 10);
      2:       return (k < 20) ? ((k % 2 == 1) ? 8'd130 : 8'd125) : ((k == 20) ? 8'd119 : 8'd130);
      3:       return (k < 5) ? 8'd110 : 8'd100;
      default: return 8'd255;
    endcase
  endfunction

  // Arms, then streams pattern samples until o_done or the cycle budget runs out.
  task automatic run(input int pid, input bit gate, input int stop_at, input int budget,
                     output int cycles, output bit got_done);
    int k = 0;
    bit stopped = 0;
    got_done = 0;
    cycles = 0;
    log_addr.delete();
    log_data.delete();
    i_start = 1; i_stop = 0; i_sample_en = 0;
    @(negedge clk);
    i_start = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      i_sample_en = gate ? (cyc % 2 == 0) : 1'b1;
      i_adc_data  = pat(pid, k);
      i_stop      = (k == stop_at) && !stopped;
      // A re-arm request while busy must be ignored.
      i_start     = (cyc == 6);
      @(negedge clk);
      if (i_stop) begin
        stopped = 1;
        check("busy_after_stop", o_busy, 0);
      end else if (i_sample_en) begin
        k++;
      end
      i_stop = 0;
      if (o_done === 1'b1) begin
        got_done = 1;
        cycles = cyc;
        break;
      end
    end
    i_start = 0;
    i_stop = 0;
    i_sample_en = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit gd;
    rst = 1;
    i_start = 0; i_stop = 0; i_sample_en = 1; i_adc_data = 0;
    i_level = 0; i_hyst = 0; i_slope = 0; i_auto = 0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", o_wr_en, 0);
    check("rst_wr_addr", o_wr_addr, 0);
    check("rst_wr_data", o_wr_data, 0);
    check("rst_start_addr", o_start_addr, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_auto", o_auto_trig, 0);
    rst = 0;
    @(negedge clk);

    // Start and stop together in IDLE: stays idle.
    i_start = 1; i_stop = 1;
    @(negedge clk);
    i_start = 0; i_stop = 0;
    check("idle_start_stop_busy", o_busy, 0);

    // Rising ramp: trigger on 130 at write 13.
    i_slope = 0; i_level = 128; i_hyst = 4; i_auto = 0;
    run(1, 0, -1, 100, cyc, gd);
    check("t1_done_seen", gd, 1);
    check("t1_cycles", cyc, 26);
    check("t1_writes", log_addr.size(), 25);
    check("t1_start", o_start_addr, 9);
    check("t1_trig_addr", log_addr[13], 13);
    check("t1_trig_data", log_data[13], 130);
    check("t1_last_addr", log_addr[24], 8);
    check("t1_auto", o_auto_trig, 0);

    // Hysteresis reject: 125/130 oscillation never arms; 119 then 130 triggers.
    i_hyst = 8;
    run(2, 0, -1, 100, cyc, gd);
    check("t2_done_seen", gd, 1);
    check("t2_writes", log_addr.size(), 33);
    check("t2_start", o_start_addr, 1);
    check("t2_arm_data", log_data[20], 119);
    check("t2_trig_data", log_data[21], 130);

    // Falling edge.
    i_slope = 1; i_level = 100; i_hyst = 2;
    run(3, 0, -1, 100, cyc, gd);
    check("t3_done_seen", gd, 1);
    check("t3_writes", log_addr.size(), 17);
    check("t3_start", o_start_addr, 1);
    check("t3_trig_data", log_data[5], 100);

    // Saturated threshold without auto: never triggers, abort with stop.
    i_level = 254; i_hyst = 4; i_auto = 0;
    run(4, 0, -1, 60, cyc, gd);
    check("t4a_no_done", gd, 0);
    check("t4a_busy", o_busy, 1);
    i_stop = 1;
    @(negedge clk);
    i_stop = 0;
    check("t4a_stop_busy", o_busy, 0);
    check("t4a_start_kept", o_start_addr, 1);

    // Same with auto: forced trigger on the 20th ARMED sample.
    i_auto = 1;
    run(4, 0, -1, 100, cyc, gd);
    check("t4b_done_seen", gd, 1);
    check("t4b_writes", log_addr.size(), 35);
    check("t4b_start", o_start_addr, 3);
    check("t4b_auto", o_auto_trig, 1);

    // Stop two cycles after the trigger.
    i_slope = 0; i_level = 128; i_hyst = 4; i_auto = 0;
    run(1, 0, 15, 40, cyc, gd);
    check("t5_no_done", gd, 0);
    check("t5_busy", o_busy, 0);
    check("t5_writes", log_addr.size(), 15);
    check("t5_start", o_start_addr, 9);
    check("t5_auto_cleared", o_auto_trig, 0);

    // Gated samples: same writes, about twice the cycles.
    run(1, 1, -1, 120, cyc, gd);
    check("t6_done_seen", gd, 1);
    check("t6_cycles", cyc, 51);
    check("t6_writes", log_addr.size(), 25);
    check("t6_start", o_start_addr, 9);
    for (int i = 0; i < log_addr.size(); i++) begin
      check("t6_addr", log_addr[i], i % BL);
      check("t6_data", log_data[i], pat(1, i));
    end

    // Asynchronous reset while ARMED, then a clean capture.
    run(1, 0, -1, 8, cyc, gd);
    check("t7_no_done", gd, 0);
    check("t7_busy_pre", o_busy, 1);
    #2 rst = 1;
    #1;
    check("t7_rst_wr_en", o_wr_en, 0);
    check("t7_rst_wr_addr", o_wr_addr, 0);
    check("t7_rst_wr_data", o_wr_data, 0);
    check("t7_rst_start", o_start_addr, 0);
    check("t7_rst_busy", o_busy, 0);
    check("t7_rst_done", o_done, 0);
    check("t7_rst_auto", o_auto_trig, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    run(1, 0, -1, 100, cyc, gd);
    check("t7_done_seen", gd, 1);
    check("t7_first_addr", log_addr[0], 0);
    check("t7_writes", log_addr.size(), 25);
    check("t7_start", o_start_addr, 9);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
